// File: rtl/cpu_bus_mux.sv
// CPU bus multiplexer: address/control frame over 8 pins, data on uio.
// Optional data-phase timeout is built when BUS_TIMEOUT_EN is defined.
module cpu_bus_mux #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ext_rdy,
  output logic [7:0]  pin_out,
  input  logic [7:0]  pin_uio_in,
  output logic [7:0]  pin_uio_out,
  output logic [7:0]  pin_uio_oe,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR_A = 2'd1,
    ADDR_B = 2'd2,
    DATA   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [10:0] addr_q;
  logic [10:0] addr_nx;
  logic        rnw_q;
  logic        rnw_nx;
  logic [7:0]  wdata_q;
  logic [7:0]  wdata_nx;
  logic        done;
  logic        tmo;
  logic        ack_nx;
  logic [7:0]  rdata_nx;
  logic [7:0]  pin_nx;
  logic [7:0]  oe_nx;
  logic [7:0]  uo_nx;

  if (WAIT_MAX < 1 || WAIT_MAX > 15) begin : g_wait_max_range
    $error("WAIT_MAX must be 1..15");
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  logic [3:0] wait_cnt;
  logic [3:0] cnt_nx;
  logic       err_q;
  logic       err_nx;

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Next state, request latching and data-phase completion.
  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    rnw_nx   = rnw_q;
    wdata_nx = wdata_q;
    done     = 1'b0;
    tmo      = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_nx   = wait_cnt;
    err_nx   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          addr_nx  = cpu_addr;
          rnw_nx   = cpu_rnw;
          wdata_nx = cpu_wdata;
          state_nx = ADDR_A;
        end
      end
      ADDR_A: state_nx = ADDR_B;
      ADDR_B: begin
        state_nx = DATA;
`ifdef BUS_TIMEOUT_EN
        cnt_nx   = 4'd0;
`endif
      end
      DATA: begin
        if (ext_rdy) begin
          done = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else begin
          cnt_nx = wait_cnt + 4'd1;
          if (cnt_nx == WAIT_LIM) begin
            tmo    = 1'b1;
            done   = 1'b1;
            err_nx = 1'b1;
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
    if (done) begin
      state_nx = IDLE;
    end
    ack_nx   = done;
    rdata_nx = cpu_rdata;
    if (done && rnw_q) begin
      rdata_nx = tmo ? 8'hFF : pin_uio_in;
    end
  end

  // Pin frame for the state being entered, so pins are registered.
  always_comb begin
    pin_nx = 8'h00;
    oe_nx  = 8'h00;
    uo_nx  = 8'h00;
    unique case (1'b1)
      (state_nx == ADDR_A): begin
        pin_nx = {1'b1, addr_nx[6:0]};
      end
      (state_nx == ADDR_B): begin
        pin_nx = {2'b01, rnw_nx, 1'b0, addr_nx[10:7]};
      end
      (state_nx == DATA): begin
        pin_nx = {2'b00, rnw_nx, 1'b1, addr_nx[10:7]};
        if (!rnw_nx) begin
          oe_nx = 8'hFF;
          uo_nx = wdata_nx;
        end
      end
      default: begin
        pin_nx = 8'h00;
      end
    endcase
  end

  // State and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= 11'd0;
      rnw_q   <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      rnw_q   <= rnw_nx;
      wdata_q <= wdata_nx;
    end
  end

  // Registered pin and CPU-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_out     <= 8'h00;
      pin_uio_oe  <= 8'h00;
      pin_uio_out <= 8'h00;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 8'h00;
    end else begin
      pin_out     <= pin_nx;
      pin_uio_oe  <= oe_nx;
      pin_uio_out <= uo_nx;
      cpu_ack     <= ack_nx;
      cpu_rdata   <= rdata_nx;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Data-phase wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= cnt_nx;
      err_q    <= err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_bus_mux.sv
// Testbench for cpu_bus_mux: per-scenario tasks with an rdata scoreboard.
// Define BUS_TIMEOUT_EN to exercise the timeout build.
module tb_cpu_bus_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b0;
  logic [10:0] cpu_addr = 11'd0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        ext_rdy = 1'b0;
  logic [7:0]  pin_out;
  logic [7:0]  pin_uio_in = 8'h00;
  logic [7:0]  pin_uio_out;
  logic [7:0]  pin_uio_oe;
  logic        bus_err;

  cpu_bus_mux #(.WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_rnw    (cpu_rnw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .ext_rdy    (ext_rdy),
    .pin_out    (pin_out),
    .pin_uio_in (pin_uio_in),
    .pin_uio_out(pin_uio_out),
    .pin_uio_oe (pin_uio_oe),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mdl_rdata = 8'h00;
  logic [7:0] got_rd;

  logic [7:0] pin_log[0:63];
  logic [7:0] oe_log[0:63];
  logic [7:0] uo_log[0:63];
  logic       ack_log[0:63];
  logic       rdy_seq[0:63];
  int         lat;

  function automatic logic [7:0] f_a(input logic [10:0] a);
    return {1'b1, a[6:0]};
  endfunction

  function automatic logic [7:0] f_b(input logic r, input logic [10:0] a);
    return {2'b01, r, 1'b0, a[10:7]};
  endfunction

  function automatic logic [7:0] f_d(input logic r, input logic [10:0] a);
    return {2'b00, r, 1'b1, a[10:7]};
  endfunction

  task automatic set_rdy(input logic v);
    for (int i = 0; i < 64; i++) rdy_seq[i] = v;
  endtask

  task automatic issue(input logic r, input logic [10:0] a,
                       input logic [7:0] wd);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rnw   = r;
    cpu_addr  = a;
    cpu_wdata = wd;
    ext_rdy   = rdy_seq[0];
  endtask

  task automatic collect(input bit keep);
    lat = 0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      pin_log[k] = pin_out;
      oe_log[k]  = pin_uio_oe;
      uo_log[k]  = pin_uio_out;
      ack_log[k] = cpu_ack;
      ext_rdy    = rdy_seq[k];
      if (cpu_ack) begin
        lat = k;
        if (!keep) cpu_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic pop_rdata(input string nm);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, rdata %h", nm, cpu_rdata);
    end else begin
      got_rd = exp_q.pop_front();
      if (cpu_rdata !== got_rd) begin
        errors++;
        $display("FAIL %s rdata got %h want %h", nm, cpu_rdata, got_rd);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (pin_out !== 8'h00 || pin_uio_oe !== 8'h00 ||
        pin_uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_pins got %h/%h/%h want 00/00/00",
               pin_out, pin_uio_oe, pin_uio_out);
    end
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cpu got ack %b rd %h err %b want 0 00 0",
               cpu_ack, cpu_rdata, bus_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pin_out !== 8'h00 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %h ack %b want 00 0",
               pin_out, cpu_ack);
    end
  endtask

  task automatic test_read;
    set_rdy(1'b1);
    pin_uio_in = 8'hA5;
    mdl_rdata  = 8'hA5;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h100, 8'h00);
    collect(1'b0);
    checks++;
    if (pin_log[1] !== 8'h80 || pin_log[2] !== 8'h62 ||
        pin_log[3] !== 8'h32) begin
      errors++;
      $display("FAIL read_frame got %h %h %h want 80 62 32",
               pin_log[1], pin_log[2], pin_log[3]);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL read_latency got %0d want 4", lat);
    end
    checks++;
    if (oe_log[3] !== 8'h00 || uo_log[3] !== 8'h00) begin
      errors++;
      $display("FAIL read_oe got %h/%h want 00/00", oe_log[3], uo_log[3]);
    end
    pop_rdata("read_rdata");
  endtask

  task automatic test_write;
    set_rdy(1'b1);
    pin_uio_in = 8'h00;
    exp_q.push_back(mdl_rdata);
    issue(1'b0, 11'h7FF, 8'h3C);
    collect(1'b0);
    checks++;
    if (pin_log[1] !== 8'hFF || pin_log[2] !== 8'h4F ||
        pin_log[3] !== 8'h1F) begin
      errors++;
      $display("FAIL write_frame got %h %h %h want FF 4F 1F",
               pin_log[1], pin_log[2], pin_log[3]);
    end
    checks++;
    if (oe_log[1] !== 8'h00 || oe_log[2] !== 8'h00 ||
        oe_log[3] !== 8'hFF || oe_log[4] !== 8'h00) begin
      errors++;
      $display("FAIL write_oe got %h %h %h %h want 00 00 FF 00",
               oe_log[1], oe_log[2], oe_log[3], oe_log[4]);
    end
    checks++;
    if (uo_log[3] !== 8'h3C || uo_log[2] !== 8'h00) begin
      errors++;
      $display("FAIL write_data got %h/%h want 3C/00",
               uo_log[3], uo_log[2]);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL write_latency got %0d want 4", lat);
    end
    pop_rdata("write_keeps_rdata");
  endtask

  task automatic test_wait;
    int ndata;
    set_rdy(1'b1);
    rdy_seq[1] = 1'b0;
    rdy_seq[3] = 1'b0;
    rdy_seq[4] = 1'b0;
    rdy_seq[5] = 1'b0;
    pin_uio_in = 8'h5A;
    mdl_rdata  = 8'h5A;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h2AB, 8'h00);
    collect(1'b0);
    ndata = 0;
    for (int k = 1; k < lat; k++) begin
      if (pin_log[k] === f_d(1'b1, 11'h2AB)) ndata++;
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL wait_latency got %0d want 7", lat);
    end
    checks++;
    if (ndata !== 4) begin
      errors++;
      $display("FAIL wait_data_cycles got %0d want 4", ndata);
    end
    checks++;
    if (pin_log[1] !== f_a(11'h2AB) || pin_log[2] !== f_b(1'b1, 11'h2AB)) begin
      errors++;
      $display("FAIL wait_addr got %h %h want %h %h", pin_log[1],
               pin_log[2], f_a(11'h2AB), f_b(1'b1, 11'h2AB));
    end
    pop_rdata("wait_rdata");
  endtask

  task automatic test_back_to_back;
    set_rdy(1'b1);
    pin_uio_in = 8'h11;
    mdl_rdata  = 8'h11;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h055, 8'h00);
    collect(1'b1);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d want 4", lat);
    end
    pop_rdata("b2b_first_rdata");
    cpu_addr   = 11'h3C0;
    pin_uio_in = 8'h22;
    mdl_rdata  = 8'h22;
    exp_q.push_back(mdl_rdata);
    collect(1'b0);
    checks++;
    if (pin_log[1] !== f_a(11'h3C0) || ack_log[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_gap got %h ack %b want %h ack 0",
               pin_log[1], ack_log[1], f_a(11'h3C0));
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d want 4", lat);
    end
    pop_rdata("b2b_second_rdata");
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || pin_out !== 8'h00) begin
      errors++;
      $display("FAIL b2b_single_ack got ack %b pin %h want 0 00",
               cpu_ack, pin_out);
    end
  endtask

  task automatic test_reset_mid;
    int nack;
    set_rdy(1'b0);
    issue(1'b0, 11'h123, 8'h99);
    repeat (3) @(negedge clk);
    checks++;
    if (pin_uio_oe !== 8'hFF || pin_uio_out !== 8'h99) begin
      errors++;
      $display("FAIL mid_data_oe got %h/%h want FF/99",
               pin_uio_oe, pin_uio_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pin_uio_oe !== 8'h00 || pin_uio_out !== 8'h00 ||
        pin_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %h/%h/%h want 00/00/00",
               pin_uio_oe, pin_uio_out, pin_out);
    end
    cpu_req = 1'b0;
    mdl_rdata = 8'h00;
    nack = 0;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ack) nack++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ack) nack++;
    end
    checks++;
    if (nack !== 0 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL abort_no_ack got acks %0d rd %h want 0 00",
               nack, cpu_rdata);
    end
    set_rdy(1'b1);
    pin_uio_in = 8'hC3;
    mdl_rdata  = 8'hC3;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h001, 8'h00);
    collect(1'b0);
    checks++;
    if (pin_log[1] !== 8'h81 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset_xfer got %h lat %0d want 81 lat 4",
               pin_log[1], lat);
    end
    pop_rdata("after_reset_rdata");
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout;
    set_rdy(1'b0);
    pin_uio_in = 8'h77;
    mdl_rdata  = 8'hFF;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h000, 8'h00);
    collect(1'b0);
    checks++;
    if (lat !== 18) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 18", lat);
    end
    pop_rdata("timeout_rdata");
    checks++;
    if (bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got %b want 1", bus_err);
    end
    set_rdy(1'b1);
    pin_uio_in = 8'h44;
    mdl_rdata  = 8'h44;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h010, 8'h00);
    collect(1'b0);
    pop_rdata("post_timeout_rdata");
    checks++;
    if (bus_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", bus_err);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset got %b want 0", bus_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`else
  task automatic test_no_timeout;
    set_rdy(1'b0);
    rdy_seq[22] = 1'b1;
    pin_uio_in = 8'h6E;
    mdl_rdata  = 8'h6E;
    exp_q.push_back(mdl_rdata);
    issue(1'b1, 11'h000, 8'h00);
    collect(1'b0);
    checks++;
    if (lat !== 23) begin
      errors++;
      $display("FAIL long_wait_latency got %0d want 23", lat);
    end
    pop_rdata("long_wait_rdata");
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL no_err got %b want 0", bus_err);
    end
  endtask
`endif

  initial begin
    set_rdy(1'b1);
    test_reset;
    test_read;
    test_write;
    test_wait;
    test_back_to_back;
    test_reset_mid;
`ifdef BUS_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_mux.md
CPU_BUS_MUX -- requirements
Module: cpu_bus_mux

Interface
REQ-001 SHALL: parameter WAIT_MAX, default 15, maximum data-phase wait cycles before timeout (used only when BUS_TIMEOUT_EN is defined; 1..15).
REQ-002 SHALL: clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL: cpu_req  input  1  CPU bus cycle request; held by the CPU until cpu_ack.
REQ-005 SHALL: cpu_rnw  input  1  1 = read, 0 = write.
REQ-006 SHALL: cpu_addr  input  11  CPU byte address.
REQ-007 SHALL: cpu_wdata  input  8  write data (the CPU accumulator).
REQ-008 SHALL: cpu_rdata  output  8  read data, valid while cpu_ack=1, held until the next read completes.
REQ-009 SHALL: cpu_ack  output  1  one-cycle pulse marking bus cycle completion.
REQ-010 SHALL: ext_rdy  input  1  external memory ready, driven from ui_in[0].
REQ-011 SHALL: pin_out  output  8  to uo_out; time-multiplexed address/control frame.
REQ-012 SHALL: pin_uio_in  input  8  from uio_in; read data.
REQ-013 SHALL: pin_uio_out  output  8  to uio_out; write data.
REQ-014 SHALL: pin_uio_oe  output  8  to uio_oe; 8'hFF drive, 8'h00 input.
REQ-015 SHALL: bus_err  output  1  sticky timeout flag (constant 0 when BUS_TIMEOUT_EN is undefined).

Function
REQ-016 SHALL: FSM states are IDLE, ADDR_A, ADDR_B, DATA; transitions are IDLE->ADDR_A->ADDR_B->DATA->IDLE, with all outputs registered.
REQ-017 SHALL: on a clock edge in IDLE with cpu_req=1, latch cpu_addr, cpu_rnw and cpu_wdata and enter ADDR_A.
REQ-018 SHALL: cpu_req in any non-IDLE state is ignored, and the latched values are not updated.
REQ-019 SHALL: ADDR_A lasts exactly 1 cycle, with pin_out = {1'b1, addr[6:0]}.
REQ-020 SHALL: ADDR_B lasts exactly 1 cycle, with pin_out = {2'b01, rnw, 1'b0, addr[10:7]}.
REQ-021 SHALL: in DATA, pin_out = {2'b00, rnw, 1'b1, addr[10:7]}.
REQ-022 SHALL: in IDLE, pin_out = 8'h00.
REQ-023 SHALL: in a DATA write, pin_uio_oe = 8'hFF and pin_uio_out = the latched wdata.
REQ-024 SHALL: in every other state and for every read, pin_uio_oe = 8'h00 and pin_uio_out = 8'h00.
REQ-025 SHALL: DATA exits on the first edge sampling ext_rdy=1; DATA therefore lasts at least 1 cycle, and ext_rdy outside DATA is ignored.
REQ-026 SHALL: on DATA exit, cpu_ack=1 for exactly the following cycle (state IDLE); for a read, cpu_rdata is loaded with pin_uio_in sampled at that edge.
REQ-027 SHALL: minimum request-to-ack latency is 4 cycles, i.e. req sampled at edge 0 gives ack high after edge 3.
REQ-028 SHALL: cpu_req=1 during the ack cycle is accepted, giving back-to-back cycles with no idle gap.
REQ-029 SHALL: writes leave cpu_rdata unchanged.

Reset
REQ-030 SHALL: on asserting rst_n=0, immediately force state=IDLE, pin_out=8'h00, pin_uio_oe=8'h00, pin_uio_out=8'h00, cpu_ack=0, cpu_rdata=8'h00, bus_err=0, and clear the wait counter.
REQ-031 SHALL: reset mid-cycle (any state) aborts the transfer without cpu_ack, and the first request after release starts from ADDR_A.

Configuration
REQ-032 SHALL: with BUS_TIMEOUT_EN defined, a 4-bit counter clears on DATA entry and increments each DATA cycle with ext_rdy=0.
REQ-033 SHALL: with BUS_TIMEOUT_EN defined, reaching WAIT_MAX ends DATA as if ext_rdy=1, with cpu_rdata=8'hFF for reads and bus_err set until reset.
REQ-034 SHALL: with BUS_TIMEOUT_EN undefined, DATA waits for ext_rdy indefinitely, no counter is built, and bus_err is tied to 0.

Verification
REQ-035 SHALL: read with addr=11'h100, ext_rdy=1 always, pin_uio_in=8'hA5 -> pin_out 8'h80, 8'h62, 8'h32, then ack with cpu_rdata=8'hA5, 4 cycles after req.
REQ-036 SHALL: write with addr=11'h7FF, wdata=8'h3C -> pin_out 8'hFF, 8'h4F, 8'h1F; pin_uio_oe=8'hFF only in DATA, pin_uio_out=8'h3C; cpu_rdata unchanged.
REQ-037 SHALL: ext_rdy held 0 for 3 DATA cycles -> DATA lasts 4 cycles, ack after edge 6, and ext_rdy pulses in IDLE and ADDR phases have no effect.
REQ-038 SHALL: cpu_req held high across 2 reads -> second ADDR_A immediately follows the ack cycle, with one ack per transfer.
REQ-039 SHALL: rst_n pulsed low during a DATA write -> pin_uio_oe=8'h00 asynchronously, no ack, and the next request completes normally.
REQ-040 SHALL: with BUS_TIMEOUT_EN defined, WAIT_MAX=15 and ext_rdy=0 -> ack after 15 wait cycles, cpu_rdata=8'hFF, bus_err=1 and sticky until reset.
